// File: rtl/gpio_irq_ctrl.sv
// 16-pin GPIO: combinational pad drive, 2-flop input sync, optional debounce (GPIO_DEBOUNCE_EN), sticky edge IRQs.
// Latency: pinstate after 2 edges (6 debounced), pending on the next edge; no backpressure, irq_clear is W1C.
module gpio_irq_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] gpio_pad_in,
   input  logic [15:0] rf_gpio_datareg,
   input  logic [15:0] rf_gpio_tristate,
   input  logic [15:0] rf_gpio_interrupt_mask,
   input  logic [15:0] irq_clear,
   output logic [15:0] gpio_pad_out,
   output logic [15:0] gpio_pad_oe,
   output logic [15:0] ro_gpio_pinstate,
   output logic [15:0] irq_pending,
   output logic        irq
);

   logic [15:0] sync1_q;
   logic [15:0] sync2_q;
   logic [15:0] prev_q;
   logic [15:0] irq_pending_q;
   logic [15:0] irq_pending_d;
   logic [15:0] level;
   logic [15:0] edge_det;
   logic [2:0]  armed_q;
   logic        armed_full;

   assign gpio_pad_out = rf_gpio_datareg;
   assign gpio_pad_oe  = ~rf_gpio_tristate;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= gpio_pad_in;
         sync2_q <= sync1_q;
      end
   end

`ifdef GPIO_DEBOUNCE_EN
   logic [15:0]       stable_q;
   logic [15:0]       stable_d;
   logic [15:0][1:0]  cnt_q;
   logic [15:0][1:0]  cnt_d;

   // A pin must disagree with its stable value for 4 straight cycles to flip.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      for (int i = 0; i < 16; i++) begin
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == 2'd3) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 2'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign level = stable_q;
`else
   assign level = sync2_q;
`endif

   // Masks the spurious edge seen while prev catches up with the pads after reset.
   assign armed_full = &armed_q;
   assign edge_det   = level ^ prev_q;

   always_comb begin
      irq_pending_d = (irq_pending_q & ~irq_clear)
                    | (edge_det & rf_gpio_interrupt_mask & {16{armed_full}});
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q        <= '0;
         armed_q       <= '0;
         irq_pending_q <= '0;
      end else begin
         prev_q        <= level;
         armed_q       <= {armed_q[1:0], 1'b1};
         irq_pending_q <= irq_pending_d;
      end
   end

   assign ro_gpio_pinstate = level;
   assign irq_pending      = irq_pending_q;
   assign irq              = |irq_pending_q;

endmodule

// File: doc/gpio_irq_ctrl.md
GPIO_IRQ_CTRL -- requirements
Module: gpio_irq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all flops update on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port gpio_pad_in, input, 16, raw asynchronous pad levels.
REQ-004 SHALL have port rf_gpio_datareg, input, 16, output data from the register block.
REQ-005 SHALL have port rf_gpio_tristate, input, 16, 1 = pin high-Z (input), 0 = pin driven.
REQ-006 SHALL have port rf_gpio_interrupt_mask, input, 16, 1 = pin interrupt enabled.
REQ-007 SHALL have port irq_clear, input, 16, one-cycle write-1-to-clear strobes for pending bits.
REQ-008 SHALL have port gpio_pad_out, output, 16, pad drive value.
REQ-009 SHALL have port gpio_pad_oe, output, 16, pad output enable, 1 = drive.
REQ-010 SHALL have port ro_gpio_pinstate, output, 16, synchronized (optionally debounced) pin levels, fed back to the register block.
REQ-011 SHALL have port irq_pending, output, 16, sticky per-pin interrupt status.
REQ-012 SHALL have port irq, output, 1, OR of irq_pending.

Function
REQ-013 SHALL drive gpio_pad_out = rf_gpio_datareg and gpio_pad_oe = ~rf_gpio_tristate combinationally, bitwise.
REQ-014 SHALL pass gpio_pad_in through a 2-flop synchronizer per bit (sync1, sync2).
REQ-015 SHALL present sync2 (or the debounced level, REQ-025) on ro_gpio_pinstate; a pad change becomes visible after the 2nd rising edge.
REQ-016 SHALL register the level in a prev register each cycle; an edge is level != prev, both polarities.
REQ-017 SHALL qualify edges with a 3-bit armed shift register that fills with 1s after reset release; edges are ignored until the armed register is full.
REQ-018 SHALL set irq_pending[i] on the edge following detection when edge[i] & rf_gpio_interrupt_mask[i] is true; with no debounce this is the 3rd rising edge after the pad change.
REQ-019 SHALL clear irq_pending[i] on the rising edge where irq_clear[i]=1 and no new qualified edge exists for pin i.
REQ-020 SHALL let set win over clear when a qualified edge and irq_clear coincide on the same bit.
REQ-021 SHALL keep an already-pending bit set when its mask bit is later cleared; masking only blocks new sets.
REQ-022 SHALL derive irq as the combinational OR of the irq_pending flops, with no additional latency.
REQ-023 SHALL sample pins with gpio_pad_oe=1 like any other pin (loopback visible, interrupts possible).

Reset
REQ-024 SHALL, while reset=0, force sync1, sync2, prev, armed, irq_pending, and the debounce state to 0, giving ro_gpio_pinstate=0, irq_pending=0, and irq=0; gpio_pad_out and gpio_pad_oe follow REQ-013 at all times. Reset asserted mid-operation SHALL discard pending interrupts and in-flight debounce counts immediately.

Configuration
REQ-025 SHALL, when GPIO_DEBOUNCE_EN is defined, insert a per-pin 2-bit counter after sync2:
- the counter increments each cycle sync2 != stable and resets to 0 when they are equal;
- on the 4th consecutive differing cycle (count==3), stable <= sync2 and the counter <= 0;
- ro_gpio_pinstate and edge detection use stable, so a clean pad change appears after 6 edges and pending sets on the 7th;
- glitches shorter than 4 synchronized cycles are dropped.
REQ-026 SHALL, when GPIO_DEBOUNCE_EN is undefined, omit all debounce logic and behave per REQ-015 and REQ-018 exactly.

Verification
REQ-027 Reset: reset=0 for 2 cycles with gpio_pad_in=16'hFFFF and mask=16'hFFFF; release -> pinstate=16'hFFFF after 2 edges, irq_pending stays 16'h0000, irq=0.
REQ-028 Pad drive: datareg=16'hA5A5, tristate=16'h00FF -> pad_out=16'hA5A5 and pad_oe=16'hFF00 in the same cycle.
REQ-029 Edge interrupt: mask=16'h0001, pad_in[0] 0->1 -> pinstate[0]=1 at edge 2, irq_pending=16'h0001 and irq=1 at edge 3; pad_in[1] toggling leaves irq_pending[1]=0.
REQ-030 Clear and collision: with pending=16'h0001, pulse irq_clear=16'h0001 -> pending=0 the next edge; repeat with a qualified edge on pin 0 in the same cycle -> pending stays 1.
REQ-031 Mask removal: with pending[3]=1, set mask=0 -> pending[3] stays 1 until irq_clear[3]; further pin 3 toggles do not set it.
REQ-032 Debounce (GPIO_DEBOUNCE_EN defined): a 2-cycle pad_in[5] pulse -> no pinstate or pending change; a held 0->1 -> pinstate[5]=1 at edge 6, pending[5] at edge 7.
